// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, frame defaults and parity helper.
// UART_TX_PARITY_EN adds the PARITY state and widens the state register to 3 bits.
package uart_pkg;
    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;
    localparam int OVERSAMPLE  = 16;
`ifdef UART_TX_PARITY_EN
    localparam int SW = 3;
`else
    localparam int SW = 2;
`endif
    typedef enum logic [SW-1:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    // Narrower words are zero-extended, which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/uart_tx.sv
// uart_tx: start + DBIT data bits (LSB first) + stop interval, 16 ticks per bit.
// UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_tx_start,
    input  logic            i_s_tick,
    input  logic [DBIT-1:0] i_din,
    output logic            o_tx,
    output logic            o_tx_done_tick,
    output logic            o_busy
);
    localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

    state_t          state_reg, state_next;
    logic [4:0]      s_reg, s_next;
    logic [2:0]      n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
    logic            p_reg, p_next;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            p_reg     <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            tx_reg    <= tx_next;
`ifdef UART_TX_PARITY_EN
            p_reg     <= p_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
`ifdef UART_TX_PARITY_EN
        p_next     = p_reg;
`endif
        case (state_reg)
            IDLE:
                if (i_tx_start) begin
                    state_next = START;
                    s_next     = '0;
                    b_next     = i_din;
`ifdef UART_TX_PARITY_EN
                    p_next     = even_parity(8'(i_din));
`endif
                end
            START:
                if (i_s_tick) begin
                    if (s_reg == BIT_LAST) begin
                        state_next = DATA;
                        s_next     = '0;
                        n_next     = '0;
                    end else
                        s_next = s_reg + 5'd1;
                end
            DATA:
                if (i_s_tick) begin
                    if (s_reg == BIT_LAST) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_reg == N_LAST)
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        else
                            n_next = n_reg + 3'd1;
                    end else
                        s_next = s_reg + 5'd1;
                end
`ifdef UART_TX_PARITY_EN
            PARITY:
                if (i_s_tick) begin
                    if (s_reg == BIT_LAST) begin
                        state_next = STOP;
                        s_next     = '0;
                    end else
                        s_next = s_reg + 5'd1;
                end
`endif
            STOP:
                if (i_s_tick) begin
                    if (s_reg == STOP_LAST)
                        state_next = IDLE;
                    else
                        s_next = s_reg + 5'd1;
                end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_next        = 1'b1;
        o_tx_done_tick = 1'b0;
        case (state_reg)
            START: tx_next = 1'b0;
            DATA:  tx_next = b_reg[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_next = p_reg;
`endif
            STOP:  o_tx_done_tick = i_s_tick && (s_reg == STOP_LAST);
            default: tx_next = 1'b1;
        endcase
    end

    assign o_busy = state_reg != IDLE;
    assign o_tx   = tx_reg;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random-stimulus check of uart_tx (SB_TICK 16 and 32) against a tick-index frame model.
// Build with UART_TX_PARITY_EN to exercise the parity frame.
module tb_uart_tx;
    import uart_pkg::*;
    localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic            i_clk = 0, i_reset_n = 0, i_tx_start = 0, i_s_tick = 0;
    logic [DBIT-1:0] i_din = '0;
    logic [1:0]      tx, done, busy;
    int              errors = 0, checks = 0, period = 4, phase = 0;
    bit              stall = 0, rnd_tick = 0;

    always #5 i_clk = ~i_clk;

    uart_tx #(.DBIT(DBIT), .SB_TICK(16)) u0 (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_tx_start(i_tx_start), .i_s_tick(i_s_tick),
        .i_din(i_din), .o_tx(tx[0]), .o_tx_done_tick(done[0]), .o_busy(busy[0])
    );
    uart_tx #(.DBIT(DBIT), .SB_TICK(32)) u1 (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_tx_start(i_tx_start), .i_s_tick(i_s_tick),
        .i_din(i_din), .o_tx(tx[1]), .o_tx_done_tick(done[1]), .o_busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Line level k ticks into a frame: 16 ticks per bit, then stop level until the end.
    function automatic logic level(input logic [DBIT-1:0] w, input int k);
        int seg;
        seg = k / OVERSAMPLE;
        if (seg == 0) return 1'b0;
        if (seg <= DBIT) return w[seg-1];
        if (PB == 1 && seg == DBIT + 1) return ^w;
        return 1'b1;
    endfunction

    initial begin
        bit              armed;
        bit              mb[2];
        int              mk[2];
        logic [DBIT-1:0] mw[2];
        logic            mt[2];
        int              total;
        armed = 0;
        forever begin
            @(negedge i_clk);
            for (int d = 0; d < 2; d++) begin
                total = OVERSAMPLE * (1 + DBIT + PB) + (d == 0 ? 16 : 32);
                if (armed) begin
                    check($sformatf("tx%0d", d), 32'(tx[d]), 32'(mt[d]));
                    check($sformatf("busy%0d", d), 32'(busy[d]), 32'(mb[d]));
                    check($sformatf("done%0d", d), 32'(done[d]),
                          32'(mb[d] && i_s_tick && mk[d] == total - 1));
                end
                if (!i_reset_n) begin
                    mb[d] = 0; mk[d] = 0; mt[d] = 1'b1; mw[d] = '0;
                end else begin
                    mt[d] = mb[d] ? level(mw[d], mk[d]) : 1'b1;
                    if (!mb[d]) begin
                        if (i_tx_start) begin
                            mb[d] = 1; mk[d] = 0; mw[d] = i_din;
                        end
                    end else if (i_s_tick) begin
                        if (mk[d] == total - 1) mb[d] = 0;
                        else mk[d]++;
                    end
                end
            end
            if (!i_reset_n) armed = 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            i_s_tick = stall ? 1'b0 : rnd_tick ? ($urandom_range(0, 3) == 0) : (phase == 0);
            phase = (phase + 1) % period;
        end
    endtask

    task automatic send(input logic [DBIT-1:0] w);
        i_din = w;
        i_tx_start = 1;
        cyc(1);
        i_tx_start = 0;
        i_din = DBIT'($urandom);
    endtask

    initial begin
        logic [DBIT-1:0] words[5];
        words = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'h07};
        cyc(3);
        i_reset_n = 1;
        cyc(2);
        foreach (words[i]) begin
            send(words[i]);
            cyc(800);
        end
        send(8'h11);
        cyc(300);
        send(8'h22);
        cyc(800);
        i_tx_start = 1;
        repeat (2400) begin
            cyc(1);
            i_din = DBIT'($urandom);
        end
        i_tx_start = 0;
        cyc(800);
        send(8'h5A);
        cyc(290);
        i_reset_n = 0;
        cyc(1);
        i_reset_n = 1;
        cyc(5);
        send(8'hC3);
        cyc(800);
        send(8'h96);
        cyc(100);
        stall = 1;
        cyc(50);
        stall = 0;
        cyc(800);
        rnd_tick = 1;
        repeat (15) begin
            send(DBIT'($urandom));
            cyc($urandom_range(50, 500));
            if ($urandom_range(0, 1) == 1) send(DBIT'($urandom));
            cyc($urandom_range(100, 900));
        end
        rnd_tick = 0;
        cyc(900);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
